// File: rtl/spi_cmd_decoder_if.sv
// Byte-strobe input and register-write output bundle of the SPI command decoder.
// Handshake: a reg_* entry transfers on every rising edge where reg_valid and reg_ready are both 1;
// while reg_valid=1 and reg_ready=0 the entry on reg_addr/reg_data holds steady. U_data is taken
// only in cycles where U_data_ready=1 and has no back-pressure.
interface spi_cmd_decoder_if;
    logic       U_data_ready;
    logic [7:0] U_data;
    logic       reg_ready;
    logic       reg_valid;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;

    modport slave (
        input  U_data_ready, U_data, reg_ready,
        output reg_valid, reg_addr, reg_data
    );

    modport master (
        output U_data_ready, U_data, reg_ready,
        input  reg_valid, reg_addr, reg_data
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Framed SPI command parser (WRITE / BURST / CLRSTAT) feeding a small register-write FIFO.
// Optional mid-frame idle timeout is compiled in with SPI_CMD_TIMEOUT_EN.
module spi_cmd_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              IO_main_clk,
    input  logic              IO_rst_n,
    spi_cmd_decoder_if.slave  bus,
    output logic              busy,
    output logic [7:0]        err_count,
    output logic              fifo_overflow,
    output logic [2:0]        dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_ADDR = 3'd1,
        S_W_DATA = 3'd2,
        S_B_ADDR = 3'd3,
        S_B_CNT  = 3'd4,
        S_B_DATA = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [7:0]      err_q, err_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_addr_q [FIFO_DEPTH];
    logic [7:0]      mem_addr_d [FIFO_DEPTH];
    logic [7:0]      mem_data_q [FIFO_DEPTH];
    logic [7:0]      mem_data_d [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic [7:0]      head_addr_q, head_addr_d;
    logic [7:0]      head_data_q, head_data_d;

    logic            push_req, push_ok, pop, full;
    logic            err_inc, stat_clr;

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   tmo_q, tmo_d;
`else
    logic            unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        head_addr_d = head_addr_q;
        head_data_d = head_data_q;
        push_req    = 1'b0;
        err_inc     = 1'b0;
        stat_clr    = 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
        tmo_d       = '0;
`endif

        if (bus.U_data_ready) begin
            case (state_q)
                S_IDLE: begin
                    case (bus.U_data)
                        8'h80:   state_d = S_W_ADDR;
                        8'h81:   state_d = S_B_ADDR;
                        8'h82:   stat_clr = 1'b1;
                        default: err_inc = 1'b1;
                    endcase
                end
                S_W_ADDR: begin
                    addr_d  = bus.U_data;
                    state_d = S_W_DATA;
                end
                S_W_DATA: begin
                    push_req = 1'b1;
                    state_d  = S_IDLE;
                end
                S_B_ADDR: begin
                    addr_d  = bus.U_data;
                    state_d = S_B_CNT;
                end
                S_B_CNT: begin
                    cnt_d   = bus.U_data;
                    state_d = (bus.U_data == 8'h00) ? S_IDLE : S_B_DATA;
                end
                S_B_DATA: begin
                    // Counter and address advance even when the FIFO drops the write.
                    push_req = 1'b1;
                    addr_d   = addr_q + 8'h01;
                    cnt_d    = cnt_q - 8'h01;
                    if (cnt_q == 8'h01) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef SPI_CMD_TIMEOUT_EN
        else if (state_q != S_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                err_inc = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif

        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = valid_q && bus.reg_ready;
        push_ok = push_req && (!full || pop);

        if (push_ok) begin
            mem_addr_d[wr_ptr_q] = addr_q;
            mem_data_d[wr_ptr_q] = bus.U_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push_ok) - CW'(pop);
        valid_d = (count_d != '0);

        // Head register: take the pushed entry if it becomes the only one, else the next stored one.
        if (push_ok && ((count_q - CW'(pop)) == '0)) begin
            head_addr_d = addr_q;
            head_data_d = bus.U_data;
        end else if (pop && valid_d) begin
            head_addr_d = mem_addr_q[rd_ptr_d];
            head_data_d = mem_data_q[rd_ptr_d];
        end

        if (stat_clr) begin
            err_d = 8'h00;
            ovf_d = 1'b0;
        end else begin
            if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'h01;
            if (push_req && !push_ok) ovf_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge IO_main_clk) begin
        if (!IO_rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 8'h00;
            cnt_q       <= 8'h00;
            busy_q      <= 1'b0;
            err_q       <= 8'h00;
            ovf_q       <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            head_addr_q <= 8'h00;
            head_data_q <= 8'h00;
`ifdef SPI_CMD_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
`ifdef SPI_CMD_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign bus.reg_valid = valid_q;
    assign bus.reg_addr  = head_addr_q;
    assign bus.reg_data  = head_data_q;
    assign busy          = busy_q;
    assign err_count     = err_q;
    assign fifo_overflow = ovf_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: command framing, burst wrap, overflow, errors, timeout, reset.
module tb_spi_cmd_decoder;
    logic       IO_main_clk;
    logic       IO_rst_n;
    logic       busy;
    logic [7:0] err_count;
    logic       fifo_overflow;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_mis = 0;
    logic [15:0] exp_q[$];

    spi_cmd_decoder_if bus ();

    spi_cmd_decoder #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .IO_main_clk   (IO_main_clk),
        .IO_rst_n      (IO_rst_n),
        .bus           (bus.slave),
        .busy          (busy),
        .err_count     (err_count),
        .fifo_overflow (fifo_overflow),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog
    initial begin
        IO_main_clk = 1'b0;
        forever #5 IO_main_clk = ~IO_main_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every accepted transfer must match the next expected entry
    always @(negedge IO_main_clk) begin
        if (IO_rst_n === 1'b1 && bus.reg_valid === 1'b1 && bus.reg_ready === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_mis++;
                $error("FAIL pop_unexpected: observed %0h/%0h expected no transfer", bus.reg_addr, bus.reg_data);
            end
            if (exp_q.size() != 0) check("pop_entry", {16'h0, bus.reg_addr, bus.reg_data}, {16'h0, exp_q.pop_front()});
        end
    end

    // Driver tasks (called at posedge + 1)
    task automatic tick(input int n);
        repeat (n) @(posedge IO_main_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.U_data       = b;
        bus.U_data_ready = 1'b1;
        tick(1);
        bus.U_data_ready = 1'b0;
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drain(input string tag, input int budget);
        bus.reg_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && bus.reg_valid === 1'b0) break;
            tick(1);
        end
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_valid"}, {31'h0, bus.reg_valid}, 0);
    endtask

    initial begin
        IO_rst_n         = 1'b0;
        bus.U_data_ready = 1'b0;
        bus.U_data       = 8'h00;
        bus.reg_ready    = 1'b0;
        tick(3);
        check("rst_valid", {31'h0, bus.reg_valid}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_err", {24'h0, err_count}, 0);
        check("rst_ovf", {31'h0, fifo_overflow}, 0);
        check("rst_addr_data", {16'h0, bus.reg_addr, bus.reg_data}, 0);
        IO_rst_n = 1'b1;
        tick(1);

        // Single write
        bus.reg_ready = 1'b1;
        expect_wr(8'h12, 8'h34);
        send_byte(8'h80);
        check("wr_busy_mid", {31'h0, busy}, 1);
        send_byte(8'h12);
        send_byte(8'h34);
        check("wr_valid_n1", {31'h0, bus.reg_valid}, 1);
        check("wr_head", {16'h0, bus.reg_addr, bus.reg_data}, 32'h1234);
        check("wr_busy_end", {31'h0, busy}, 0);
        drain("wr", 10);

        // Burst with address wrap, back-to-back strobes
        expect_wr(8'hFE, 8'hA0);
        expect_wr(8'hFF, 8'hA1);
        expect_wr(8'h00, 8'hA2);
        send_byte(8'h81); send_byte(8'hFE); send_byte(8'h03);
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
        check("burst_busy_end", {31'h0, busy}, 0);
        drain("burst", 10);

        // Zero-count burst: back to IDLE, no writes
        send_byte(8'h81); send_byte(8'h40); send_byte(8'h00);
        check("burst0_busy", {31'h0, busy}, 0);
        tick(2);
        check("burst0_valid", {31'h0, bus.reg_valid}, 0);

        // Framing errors
        send_byte(8'h00); send_byte(8'h7F); send_byte(8'h90);
        check("ferr_count3", {24'h0, err_count}, 3);
        check("ferr_valid", {31'h0, bus.reg_valid}, 0);
        check("ferr_busy", {31'h0, busy}, 0);

        // Overflow: 6-byte burst into a 4-deep FIFO with no consumer
        bus.reg_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_wr(8'h10 + 8'(i), 8'hC0 + 8'(i));
        send_byte(8'h81); send_byte(8'h10); send_byte(8'h06);
        for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i));
        check("ovf_flag", {31'h0, fifo_overflow}, 1);
        check("ovf_busy", {31'h0, busy}, 0);
        tick(3);
        check("ovf_head_hold", {15'h0, bus.reg_valid, bus.reg_addr, bus.reg_data}, 32'h1_10C0);
        drain("ovf", 20);
        send_byte(8'h82);
        check("clr_ovf", {31'h0, fifo_overflow}, 0);
        check("clr_err", {24'h0, err_count}, 0);

        // Saturation
        for (int i = 0; i < 300; i++) send_byte(8'h40 + 8'(i % 32));
        check("err_sat", {24'h0, err_count}, 32'hFF);
        send_byte(8'h82);
        check("clr_err2", {24'h0, err_count}, 0);

        // Stalled partial frame
        bus.reg_ready = 1'b1;
        send_byte(8'h80); send_byte(8'h12);
        tick(16);
`ifdef SPI_CMD_TIMEOUT_EN
        check("tmo_busy", {31'h0, busy}, 0);
        check("tmo_err", {24'h0, err_count}, 1);
        expect_wr(8'h01, 8'h02);
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h02);
`else
        check("stall_busy", {31'h0, busy}, 1);
        check("stall_err", {24'h0, err_count}, 0);
        expect_wr(8'h12, 8'h80);
        send_byte(8'h80);
        check("stall_busy_end", {31'h0, busy}, 0);
`endif
        drain("stall", 10);

        // Reset mid-burst with a non-empty FIFO
        bus.reg_ready = 1'b0;
        send_byte(8'h55);
        send_byte(8'h80); send_byte(8'h0A); send_byte(8'h0B);
        send_byte(8'h81); send_byte(8'h20); send_byte(8'h04);
        send_byte(8'hD0); send_byte(8'hD1);
        check("pre_rst_err", {24'h0, err_count}, 1);
        check("pre_rst_head", {15'h0, bus.reg_valid, bus.reg_addr, bus.reg_data}, 32'h1_0A0B);
        IO_rst_n = 1'b0;
        tick(1);
        IO_rst_n = 1'b1;
        exp_q.delete();
        check("mid_rst_valid", {31'h0, bus.reg_valid}, 0);
        check("mid_rst_addr_data", {16'h0, bus.reg_addr, bus.reg_data}, 0);
        check("mid_rst_busy", {31'h0, busy}, 0);
        check("mid_rst_err", {24'h0, err_count}, 0);
        check("mid_rst_ovf", {31'h0, fifo_overflow}, 0);
        bus.reg_ready = 1'b1;
        expect_wr(8'h05, 8'h06);
        send_byte(8'h80); send_byte(8'h05); send_byte(8'h06);
        drain("post_rst", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
